mux_21_continuous: RTL and testbench
====================================

// Module: mux_21_continuous
// PURPOSE
//   2:1 multiplexer with a continuous combinational output and a registered copy.
//   OUT follows SEL/A/B with zero latency (continuous assign). OUT_Q is a
//   clock-enabled pipeline copy of OUT.
//   Also provides select-toggle detection and an optional toggle counter.
//   Used as a leaf datapath select where some consumers need a registered,
//   valid-tagged result.
// PARAMETERS
//   WIDTH  1  data width of A, B, OUT, OUT_Q
//   CNT_W  8  width of TOG_CNT (stats counter)
// PORTS
//   CLK      in   1      rising-edge clock
//   RST_N    in   1      asynchronous active-low reset
//   A        in   WIDTH  data input, selected when SEL=0
//   B        in   WIDTH  data input, selected when SEL=1
//   SEL      in   1      select
//   EN       in   1      capture enable for OUT_Q
//   OUT      out  WIDTH  combinational: SEL ? B : A
//   OUT_Q    out  WIDTH  registered OUT, updated when EN=1
//   OUT_VLD  out  1      high the cycle after a capture (registered EN)
//   SEL_TOG  out  1      one-cycle pulse: SEL changed since previous edge
//   TOG_CNT  out  CNT_W  count of SEL toggles (see CONFIGURATION)
// BEHAVIOUR
//   - OUT = SEL ? B : A. Pure continuous assign; no clock or reset dependence.
//     OUT is valid while RST_N=0.
//   - Reset (RST_N=0, async assert; deassertion takes effect at the next CLK
//     edge) drives OUT_Q=0, OUT_VLD=0, SEL_TOG=0 and TOG_CNT=0. The internal
//     SEL history register sel_d is also cleared to 0.
//   - Each CLK rising edge:
//       if EN: OUT_Q <= OUT; else OUT_Q holds. Latency is 1 cycle.
//       OUT_VLD <= EN.
//       SEL_TOG <= (SEL != sel_d); sel_d <= SEL.
//   - First edge after reset with SEL=1 gives SEL_TOG=1, because sel_d resets to 0.
//   - SEL toggling every cycle keeps SEL_TOG high continuously.
//   - Reset asserted mid-operation clears all registers immediately. No partial
//     update is held over, and OUT keeps tracking its inputs.
//   - No X-propagation special handling: SEL=X produces simulator-default OUT.
// CONFIGURATION
//   MUX21_STATS_EN defined:
//     TOG_CNT increments by 1 on each edge where SEL != sel_d.
//     Saturates at 2^CNT_W-1 and never wraps. Cleared only by reset.
//   MUX21_STATS_EN undefined:
//     No counter logic is built. TOG_CNT is tied to 0. The port is still present.
//   SEL_TOG is present in both builds.
// TESTING
//   1. Exhaustive sweep (WIDTH=1), {A,B,SEL}=0..7, 10 ns each:
//      OUT = 0,0,0,1,1,0,1,1 in that order.
//   2. Reset: RST_N=0 mid-run with OUT_Q=1 and TOG_CNT=5 -> OUT_Q, OUT_VLD,
//      SEL_TOG and TOG_CNT go to 0 at once, without waiting for CLK.
//      OUT still equals SEL?B:A.
//   3. Enable: A=1, B=0, SEL=0, EN=1 for one edge -> OUT_Q=1 and OUT_VLD=1.
//      Then EN=0 and SEL=1 -> OUT=0, OUT_Q stays 1, OUT_VLD=0.
//   4. Toggle: SEL pattern 0,1,1,0 over 4 edges after reset ->
//      SEL_TOG 0,1,0,1; TOG_CNT=2 with MUX21_STATS_EN, 0 without.
//   5. Saturation: CNT_W=2 with MUX21_STATS_EN, SEL toggled for 6 edges ->
//      TOG_CNT 1,2,3,3,3,3.
//   6. Width: WIDTH=8, A=8'hA5, B=8'h3C -> OUT=8'hA5 at SEL=0 and 8'h3C at
//      SEL=1; OUT_Q matches one edge later when EN=1.

Source files
------------

// File: rtl/mux_21_continuous_if.sv
// Request/response bundle for the 2:1 select leaf: data/select/enable in,
// combinational result plus registered, valid-tagged copy and toggle stats out.
interface mux_21_continuous_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_vld;
  logic             sel_tog;
  logic [CNT_W-1:0] tog_cnt;

  modport master (
    output a, b, sel, en,
    input  out, out_q, out_vld, sel_tog, tog_cnt
  );

  modport slave (
    input  a, b, sel, en,
    output out, out_q, out_vld, sel_tog, tog_cnt
  );
endinterface

// File: rtl/mux_21_continuous.sv
// 2:1 multiplexer: zero-latency combinational OUT, enable-gated registered copy
// OUT_Q with a one-cycle valid tag, SEL change pulse, and an optional
// saturating toggle counter built only when MUX21_STATS_EN is defined
// (otherwise TOG_CNT is tied to zero).

// One bit of the datapath: combinational select plus its capture register.
module mux_21_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic sel,
  input  logic en,
  output logic out,
  output logic out_q
);
  assign out = sel ? b : a;

  // Capture the live select result when enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  out_q <= 1'b0;
    else if (en) out_q <= out;
  end
endmodule

module mux_21_continuous #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  mux_21_continuous_if.slave bus
);
  logic [WIDTH-1:0] out_w;
  logic [WIDTH-1:0] q_w;
  logic             vld_q;
  logic             sel_d;
  logic             tog_q;
  logic             tog_nxt;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      mux_21_lane u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (bus.a[i]),
        .b    (bus.b[i]),
        .sel  (bus.sel),
        .en   (bus.en),
        .out  (out_w[i]),
        .out_q(q_w[i])
      );
    end
  endgenerate

  // sel_d resets to 0, so a first edge with SEL=1 counts as a toggle.
  assign tog_nxt = (bus.sel != sel_d);

  // Valid tag follows the capture enable by one cycle; SEL history and pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      sel_d <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      vld_q <= bus.en;
      sel_d <= bus.sel;
      tog_q <= tog_nxt;
    end
  end

`ifdef MUX21_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating toggle count; sticks at all-ones until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (tog_nxt && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.tog_cnt = cnt_q;
`else
  assign bus.tog_cnt = '0;
`endif

  assign bus.out     = out_w;
  assign bus.out_q   = q_w;
  assign bus.out_vld = vld_q;
  assign bus.sel_tog = tog_q;
endmodule

// File: tb/tb_mux_21_continuous.sv
// Bench for mux_21_continuous: an 8-bit instance and a 1-bit / CNT_W=2 instance
// share one stimulus stream; a cycle-level reference model predicts every output.
module tb_mux_21_continuous;
`ifdef MUX21_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       sel = 1'b0, en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  logic [7:0] m_q;
  logic       m_vld, m_tog, m_seld;
  int         m_cnt8, m_cnt1;

  always #5 clk = ~clk;

  mux_21_continuous_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  mux_21_continuous_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

  assign bus8.a = a;    assign bus8.b = b;
  assign bus8.sel = sel; assign bus8.en = en;
  assign bus1.a = a[0]; assign bus1.b = b[0];
  assign bus1.sel = sel; assign bus1.en = en;

  mux_21_continuous #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  mux_21_continuous #(.WIDTH(1), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  task automatic model_clear();
    m_q = '0; m_vld = 0; m_tog = 0; m_seld = 0; m_cnt8 = 0; m_cnt1 = 0;
  endtask

  // One rising edge, then advance the model from the spec rules.
  task automatic step();
    @(posedge clk);
    if (en) m_q = sel ? b : a;
    m_vld = en;
    m_tog = (sel != m_seld);
    if (STATS && m_tog) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt1 = (m_cnt1 < 3)   ? m_cnt1 + 1 : 3;
    end
    m_seld = sel;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; en = 0; sel = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_clear();
    #1;
    n_checks++;
    if ({bus8.out_q, bus8.out_vld, bus8.sel_tog, bus8.tog_cnt} !== 18'h0) begin
      n_err++; $display("FAIL reset8: got q=%0h v=%0b t=%0b c=%0d expected all 0",
                        bus8.out_q, bus8.out_vld, bus8.sel_tog, bus8.tog_cnt);
    end
    n_checks++;
    if ({bus1.out_q, bus1.out_vld, bus1.sel_tog, bus1.tog_cnt} !== 5'h0) begin
      n_err++; $display("FAIL reset1: got %0b expected 0",
                        {bus1.out_q, bus1.out_vld, bus1.sel_tog, bus1.tog_cnt});
    end
  endtask

  // Exhaustive {A,B,SEL} sweep, held in reset: OUT is valid regardless.
  task automatic test_sweep();
    bit exp_t[8] = '{0, 0, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      a = {7'd0, 1'(i >> 2)}; b = {7'd0, 1'(i >> 1)}; sel = 1'(i);
      #10;
      n_checks++;
      if (bus1.out !== exp_t[i]) begin
        n_err++; $display("FAIL sweep[%0d]: got %0b expected %0b", i, bus1.out, exp_t[i]);
      end
      n_checks++;
      if (bus8.out !== {7'd0, exp_t[i]}) begin
        n_err++; $display("FAIL sweep8[%0d]: got %0h expected %0h", i, bus8.out, exp_t[i]);
      end
    end
  endtask

  task automatic test_toggle();
    bit pat[4] = '{0, 1, 1, 0};
    bit etg[4] = '{0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); sel = pat[i];
      step();
      n_checks++;
      if (bus8.sel_tog !== etg[i] || bus1.sel_tog !== m_tog) begin
        n_err++; $display("FAIL toggle[%0d]: got %0b/%0b expected %0b",
                          i, bus8.sel_tog, bus1.sel_tog, etg[i]);
      end
    end
    n_checks++;
    if (bus8.tog_cnt !== (STATS ? 8'd2 : 8'd0)) begin
      n_err++; $display("FAIL toggle_cnt: got %0d expected %0d", bus8.tog_cnt, STATS ? 2 : 0);
    end
  endtask

  task automatic test_enable();
    @(negedge clk); a = 8'd1; b = 8'd0; sel = 0; en = 1;
    step();
    n_checks++;
    if (bus8.out_q !== 8'd1 || bus8.out_vld !== 1'b1) begin
      n_err++; $display("FAIL enable_cap: got q=%0h v=%0b expected q=1 v=1", bus8.out_q, bus8.out_vld);
    end
    @(negedge clk); en = 0; sel = 1;
    #1;
    n_checks++;
    if (bus8.out !== 8'd0) begin
      n_err++; $display("FAIL enable_out: got %0h expected 0", bus8.out);
    end
    step();
    n_checks++;
    if (bus8.out_q !== 8'd1 || bus8.out_vld !== 1'b0) begin
      n_err++; $display("FAIL enable_hold: got q=%0h v=%0b expected q=1 v=0", bus8.out_q, bus8.out_vld);
    end
  endtask

  task automatic test_width();
    @(negedge clk); a = 8'hA5; b = 8'h3C; sel = 0; en = 0;
    #1;
    n_checks++;
    if (bus8.out !== 8'hA5) begin
      n_err++; $display("FAIL width_a: got %0h expected a5", bus8.out);
    end
    step();
    @(negedge clk); sel = 1; en = 1;
    #1;
    n_checks++;
    if (bus8.out !== 8'h3C) begin
      n_err++; $display("FAIL width_b: got %0h expected 3c", bus8.out);
    end
    step();
    n_checks++;
    if (bus8.out_q !== 8'h3C) begin
      n_err++; $display("FAIL width_q: got %0h expected 3c", bus8.out_q);
    end
    @(negedge clk); en = 0;
  endtask

  task automatic test_saturation();
    int e1[6] = '{1, 2, 3, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); sel = ~sel;
      step();
      n_checks++;
      if (bus1.tog_cnt !== 2'(STATS ? e1[i] : 0) || bus8.tog_cnt !== 8'(STATS ? i + 1 : 0)) begin
        n_err++; $display("FAIL sat[%0d]: got %0d/%0d expected %0d/%0d", i, bus1.tog_cnt,
                          bus8.tog_cnt, STATS ? e1[i] : 0, STATS ? i + 1 : 0);
      end
    end
  endtask

  // Build up OUT_Q=1 and five toggles, then drop reset between edges.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a = 8'hFF; b = 8'h01; en = 1; sel = ~sel;
      step();
    end
    n_checks++;
    if (bus8.out_q !== 8'h01 || bus8.tog_cnt !== 8'(STATS ? 5 : 0)) begin
      n_err++; $display("FAIL premid: got q=%0h c=%0d expected q=1 c=%0d",
                        bus8.out_q, bus8.tog_cnt, STATS ? 5 : 0);
    end
    #1; rst_n = 0; model_clear();
    #1;
    n_checks++;
    if ({bus8.out_q, bus8.out_vld, bus8.sel_tog, bus8.tog_cnt} !== 18'h0 ||
        {bus1.out_q, bus1.out_vld, bus1.sel_tog, bus1.tog_cnt} !== 5'h0) begin
      n_err++; $display("FAIL reset_mid: got q=%0h v=%0b t=%0b c=%0d expected all 0",
                        bus8.out_q, bus8.out_vld, bus8.sel_tog, bus8.tog_cnt);
    end
    a = 8'h5A; b = 8'hC3; sel = 0;
    #1;
    n_checks++;
    if (bus8.out !== 8'h5A) begin
      n_err++; $display("FAIL reset_out: got %0h expected 5a", bus8.out);
    end
    @(negedge clk); rst_n = 1; sel = 0; en = 0;
  endtask

  task automatic test_random();
    logic [7:0] eo;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom); en = ($urandom_range(0, 3) != 0);
      if (n % 50 == 49) sel = 1'($urandom);
      #1;
      eo = sel ? b : a;
      n_checks++;
      if (bus8.out !== eo || bus1.out !== eo[0]) begin
        n_err++; $display("FAIL rand_out[%0d]: got %0h expected %0h", n, bus8.out, eo);
      end
      step();
      n_checks++;
      if (bus8.out_q !== m_q || bus8.out_vld !== m_vld || bus8.sel_tog !== m_tog ||
          bus8.tog_cnt !== 8'(m_cnt8)) begin
        n_err++; $display("FAIL rand8[%0d]: got q=%0h v=%0b t=%0b c=%0d expected q=%0h v=%0b t=%0b c=%0d",
                          n, bus8.out_q, bus8.out_vld, bus8.sel_tog, bus8.tog_cnt,
                          m_q, m_vld, m_tog, m_cnt8);
      end
      n_checks++;
      if (bus1.out_q !== m_q[0] || bus1.out_vld !== m_vld || bus1.sel_tog !== m_tog ||
          bus1.tog_cnt !== 2'(m_cnt1)) begin
        n_err++; $display("FAIL rand1[%0d]: got q=%0b c=%0d expected q=%0b c=%0d",
                          n, bus1.out_q, bus1.tog_cnt, m_q[0], m_cnt1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sweep();
    test_toggle();
    test_enable();
    test_width();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
